// File: rtl/hazard_controller_if.sv
// Hazard controller signal bundle: ID/EX and IF/ID hazard inputs plus
// pipeline enables, flushes, multiplier handshake and stall statistics.
interface hazard_controller_if #(
    parameter int CNTW = 16
);
    logic            idexmemrd;
    logic [4:0]      idexrt;
    logic [4:0]      ifidrs;
    logic [4:0]      ifidrt;
    logic            ifidusesrt;
    logic            ifidmul;
    logic            branchtaken;
    logic            pcwr;
    logic            ifidwr;
    logic            ifidflush;
    logic            idexflush;
    logic            mulstart;
    logic            mulbusy;
    logic [CNTW-1:0] stallcnt;
    logic [CNTW-1:0] flushcnt;

    modport master (
        output idexmemrd, idexrt, ifidrs, ifidrt, ifidusesrt, ifidmul, branchtaken,
        input  pcwr, ifidwr, ifidflush, idexflush, mulstart, mulbusy, stallcnt, flushcnt
    );

    modport slave (
        input  idexmemrd, idexrt, ifidrs, ifidrt, ifidusesrt, ifidmul, branchtaken,
        output pcwr, ifidwr, ifidflush, idexflush, mulstart, mulbusy, stallcnt, flushcnt
    );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stall, branch flush and multiplier wait FSM.
// Define HAZARD_STATS_EN to build the saturating stall/flush statistic counters.
module hazard_controller #(
    parameter int MULCYCLES = 4,
    parameter int CNTW      = 16
) (
    input  logic                clk,
    input  logic                rstn,
    hazard_controller_if.slave  hz
);
    typedef enum logic [0:0] {RUN = 1'b0, MULWAIT = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [3:0] mulcnt_q, mulcnt_d;
    logic       loaduse_s;

    // Load in EX whose destination is a source of the instruction in ID
    always_comb begin
        loaduse_s = 1'b0;
        if (hz.idexmemrd && (hz.idexrt != 5'd0) &&
            ((hz.idexrt == hz.ifidrs) || (hz.ifidusesrt && (hz.idexrt == hz.ifidrt)))) begin
            loaduse_s = 1'b1;
        end else begin
            loaduse_s = 1'b0;
        end
    end

    // State and multiplier countdown registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= RUN;
            mulcnt_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            mulcnt_q <= mulcnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        mulcnt_d = mulcnt_q;
        case (state_q)
            RUN: begin
                if (!hz.branchtaken && !loaduse_s && hz.ifidmul) begin
                    state_d  = MULWAIT;
                    mulcnt_d = 4'(MULCYCLES - 1);
                end else begin
                    state_d  = RUN;
                end
            end
            MULWAIT: begin
                mulcnt_d = mulcnt_q - 4'd1;
                if (mulcnt_q == 4'd1) begin
                    state_d = RUN;
                end else begin
                    state_d = MULWAIT;
                end
            end
            default: begin
                state_d  = RUN;
                mulcnt_d = 4'd0;
            end
        endcase
    end

    // Pipeline control outputs; reset forces a held, flushed pipeline
    always_comb begin
        hz.pcwr      = 1'b0;
        hz.ifidwr    = 1'b0;
        hz.ifidflush = 1'b0;
        hz.idexflush = 1'b0;
        hz.mulstart  = 1'b0;
        hz.mulbusy   = (state_q == MULWAIT);
        if (!rstn) begin
            hz.ifidflush = 1'b1;
            hz.idexflush = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (hz.branchtaken) begin
                        hz.pcwr      = 1'b1;
                        hz.ifidwr    = 1'b1;
                        hz.ifidflush = 1'b1;
                        hz.idexflush = 1'b1;
                    end else if (loaduse_s) begin
                        hz.idexflush = 1'b1;
                    end else if (hz.ifidmul) begin
                        hz.mulstart  = 1'b1;
                        hz.idexflush = 1'b1;
                    end else begin
                        hz.pcwr      = 1'b1;
                        hz.ifidwr    = 1'b1;
                    end
                end
                MULWAIT: begin
                    hz.idexflush = 1'b1;
                end
                default: begin
                    hz.idexflush = 1'b1;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    logic [CNTW-1:0] stallcnt_q, stallcnt_d;
    logic [CNTW-1:0] flushcnt_q, flushcnt_d;

    // Saturating statistics: every held PC cycle counts as a stall
    always_comb begin
        stallcnt_d = stallcnt_q;
        flushcnt_d = flushcnt_q;
        case (state_q)
            RUN: begin
                if (hz.branchtaken) begin
                    if (flushcnt_q != {CNTW{1'b1}}) flushcnt_d = flushcnt_q + CNTW'(1);
                    else                            flushcnt_d = flushcnt_q;
                end else if (loaduse_s || hz.ifidmul) begin
                    if (stallcnt_q != {CNTW{1'b1}}) stallcnt_d = stallcnt_q + CNTW'(1);
                    else                            stallcnt_d = stallcnt_q;
                end else begin
                    stallcnt_d = stallcnt_q;
                end
            end
            MULWAIT: begin
                if (stallcnt_q != {CNTW{1'b1}}) stallcnt_d = stallcnt_q + CNTW'(1);
                else                            stallcnt_d = stallcnt_q;
            end
            default: begin
                stallcnt_d = stallcnt_q;
                flushcnt_d = flushcnt_q;
            end
        endcase
    end

    // Statistic registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stallcnt_q <= {CNTW{1'b0}};
            flushcnt_q <= {CNTW{1'b0}};
        end else begin
            stallcnt_q <= stallcnt_d;
            flushcnt_q <= flushcnt_d;
        end
    end

    assign hz.stallcnt = stallcnt_q;
    assign hz.flushcnt = flushcnt_q;
`else
    assign hz.stallcnt = {CNTW{1'b0}};
    assign hz.flushcnt = {CNTW{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: load-use, branch, multiply wait,
// reset during MULWAIT and counter saturation on a narrow-counter instance.
module tb_hazard_controller;
    logic clk;
    logic rstn;
    int   total;
    int   passed;
    int   fails;
    int   exp_stall;
    int   exp_flush;
    int   sat_exp;

    hazard_controller_if #(.CNTW(16)) hz ();
    hazard_controller_if #(.CNTW(4))  hz4 ();

    hazard_controller #(.MULCYCLES(4), .CNTW(16)) dut (
        .clk  (clk),
        .rstn (rstn),
        .hz   (hz.slave)
    );

    hazard_controller #(.MULCYCLES(4), .CNTW(4)) dut4 (
        .clk  (clk),
        .rstn (rstn),
        .hz   (hz4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ex(input int v);
`ifdef HAZARD_STATS_EN
        return 16'(v);
`else
        return 16'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, tracking the saturating model of the narrow instance
    task automatic cyc();
        @(posedge clk);
        if (rstn) begin
            if (sat_exp < 15) sat_exp++;
        end else begin
            sat_exp = 0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        hz.idexmemrd   = 1'b0;
        hz.idexrt      = 5'd0;
        hz.ifidrs      = 5'd0;
        hz.ifidrt      = 5'd0;
        hz.ifidusesrt  = 1'b0;
        hz.ifidmul     = 1'b0;
        hz.branchtaken = 1'b0;
    endtask

    initial begin
        total = 0; passed = 0; fails = 0;
        exp_stall = 0; exp_flush = 0; sat_exp = 0;
        rstn = 1'b0;
        idle_inputs();
        // Narrow instance sees a permanent load-use hazard
        hz4.idexmemrd   = 1'b1;
        hz4.idexrt      = 5'd3;
        hz4.ifidrs      = 5'd3;
        hz4.ifidrt      = 5'd0;
        hz4.ifidusesrt  = 1'b0;
        hz4.ifidmul     = 1'b0;
        hz4.branchtaken = 1'b0;

        #3;
        chk("rst_pcwr",      16'(hz.pcwr),      16'd0);
        chk("rst_ifidwr",    16'(hz.ifidwr),    16'd0);
        chk("rst_ifidflush", 16'(hz.ifidflush), 16'd1);
        chk("rst_idexflush", 16'(hz.idexflush), 16'd1);
        chk("rst_mulstart",  16'(hz.mulstart),  16'd0);
        chk("rst_mulbusy",   16'(hz.mulbusy),   16'd0);
        chk("rst_stallcnt",  hz.stallcnt,       16'd0);
        chk("rst_flushcnt",  hz.flushcnt,       16'd0);

        #9 rstn = 1'b1;
        cyc();
        chk("idle_pcwr",      16'(hz.pcwr),      16'd1);
        chk("idle_ifidwr",    16'(hz.ifidwr),    16'd1);
        chk("idle_idexflush", 16'(hz.idexflush), 16'd0);

        // lw $5 followed by a user of $5 in rs
        hz.idexmemrd = 1'b1; hz.idexrt = 5'd5; hz.ifidrs = 5'd5;
        #1;
        chk("lu_pcwr",      16'(hz.pcwr),      16'd0);
        chk("lu_ifidwr",    16'(hz.ifidwr),    16'd0);
        chk("lu_idexflush", 16'(hz.idexflush), 16'd1);
        chk("lu_ifidflush", 16'(hz.ifidflush), 16'd0);
        cyc(); exp_stall = 1;
        hz.idexmemrd = 1'b0;
        #1;
        chk("lu_after_pcwr", 16'(hz.pcwr), 16'd1);
        chk("lu_stallcnt",   hz.stallcnt,  ex(exp_stall));

        // Register zero never stalls; rt only matters when it is read
        hz.idexmemrd = 1'b1; hz.idexrt = 5'd0; hz.ifidrs = 5'd0;
        #1;
        chk("r0_pcwr", 16'(hz.pcwr), 16'd1);
        hz.idexrt = 5'd7; hz.ifidrs = 5'd1; hz.ifidrt = 5'd7; hz.ifidusesrt = 1'b0;
        #1;
        chk("rt_unused_pcwr", 16'(hz.pcwr), 16'd1);
        hz.ifidusesrt = 1'b1;
        #1;
        chk("rt_used_pcwr", 16'(hz.pcwr), 16'd0);
        cyc(); exp_stall = 2;
        idle_inputs();
        #1;
        chk("rt_stallcnt", hz.stallcnt, ex(exp_stall));

        // Taken branch overrides a simultaneous load-use
        hz.idexmemrd = 1'b1; hz.idexrt = 5'd5; hz.ifidrs = 5'd5; hz.branchtaken = 1'b1;
        #1;
        chk("br_ifidflush", 16'(hz.ifidflush), 16'd1);
        chk("br_idexflush", 16'(hz.idexflush), 16'd1);
        chk("br_pcwr",      16'(hz.pcwr),      16'd1);
        chk("br_ifidwr",    16'(hz.ifidwr),    16'd1);
        chk("br_mulstart",  16'(hz.mulstart),  16'd0);
        cyc(); exp_flush = 1;
        idle_inputs();
        #1;
        chk("br_flushcnt", hz.flushcnt, ex(exp_flush));
        chk("br_stallcnt", hz.stallcnt, ex(exp_stall));

        // Single multiply: start in cycle 0, busy cycles 1-3, release in cycle 4
        hz.ifidmul = 1'b1;
        #1;
        chk("mul_c0_start",   16'(hz.mulstart), 16'd1);
        chk("mul_c0_pcwr",    16'(hz.pcwr),     16'd0);
        chk("mul_c0_busy",    16'(hz.mulbusy),  16'd0);
        cyc();
        hz.ifidmul = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            #1;
            chk($sformatf("mul_c%0d_busy", i),  16'(hz.mulbusy),   16'd1);
            chk($sformatf("mul_c%0d_pcwr", i),  16'(hz.pcwr),      16'd0);
            chk($sformatf("mul_c%0d_start", i), 16'(hz.mulstart),  16'd0);
            chk($sformatf("mul_c%0d_idex", i),  16'(hz.idexflush), 16'd1);
            cyc();
        end
        exp_stall = exp_stall + 4;
        #1;
        chk("mul_c4_pcwr",  16'(hz.pcwr),    16'd1);
        chk("mul_c4_busy",  16'(hz.mulbusy), 16'd0);
        chk("mul_stallcnt", hz.stallcnt,     ex(exp_stall));

        // Back-to-back multiplies: second start exactly in cycle 4
        hz.ifidmul = 1'b1;
        #1;
        chk("b2b_c0_start", 16'(hz.mulstart), 16'd1);
        for (int i = 0; i < 4; i++) cyc();
        #1;
        chk("b2b_c4_start", 16'(hz.mulstart), 16'd1);
        chk("b2b_c4_busy",  16'(hz.mulbusy),  16'd0);
        cyc();
        hz.ifidmul = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        exp_stall = exp_stall + 8;
        #1;
        chk("b2b_c8_pcwr",  16'(hz.pcwr), 16'd1);
        chk("b2b_stallcnt", hz.stallcnt,  ex(exp_stall));

        // Reset pulled in cycle 2 of MULWAIT
        hz.ifidmul = 1'b1;
        #1;
        cyc();
        hz.ifidmul = 1'b0;
        cyc();
        #1;
        chk("rmw_busy_before", 16'(hz.mulbusy), 16'd1);
        rstn = 1'b0;
        #1;
        chk("rmw_busy_async", 16'(hz.mulbusy),   16'd0);
        chk("rmw_pcwr",       16'(hz.pcwr),      16'd0);
        chk("rmw_ifidflush",  16'(hz.ifidflush), 16'd1);
        chk("rmw_stallcnt",   hz.stallcnt,       16'd0);
        cyc();
        rstn = 1'b1;
        #1;
        chk("rmw_rel_pcwr",  16'(hz.pcwr),     16'd1);
        chk("rmw_rel_start", 16'(hz.mulstart), 16'd0);
        cyc();
        #1;
        chk("rmw_rel2_pcwr",  16'(hz.pcwr),    16'd1);
        chk("rmw_rel2_busy",  16'(hz.mulbusy), 16'd0);
        chk("rmw_rel2_start", 16'(hz.mulstart), 16'd0);

        // Narrow instance: count up to 15, then hold
        while (sat_exp < 14) cyc();
        chk("sat_14", 16'(hz4.stallcnt), ex(14));
        cyc();
        chk("sat_15", 16'(hz4.stallcnt), ex(15));
        for (int i = 0; i < 5; i++) cyc();
        chk("sat_hold", 16'(hz4.stallcnt), ex(15));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
